// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the unified memory port arbiter.
//   arb_state_t : arbiter FSM state encoding
//   func3_t     : load/store access-size codes (funct3 low bits; loads and
//                 stores share encodings, bit 2 marks unsigned loads)
//   CNT_W_DEF   : default performance counter width
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IBUSY = 2'd1,
    DBUSY = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,  // LB / SB
    F3_H  = 3'b001,  // LH / SH
    F3_W  = 3'b010,  // LW / SW
    F3_BU = 3'b100,  // LBU
    F3_HU = 3'b101   // LHU
  } func3_t;

  localparam int unsigned CNT_W_DEF = 32;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundle of the fetch port, load/store port and memory
// port around the arbiter.
//   master : arbiter view (consumes requests/ack, drives ready/stall/mem_*)
//   slave  : environment view (pipeline stages and the memory)
// Fetch:  if_req, if_addr, if_flush -> ; <- if_rdata, if_ready, if_stall
// Data:   d_req, d_we, d_func3, d_addr, d_wdata -> ; <- d_rdata, d_ready, d_stall
// Memory: <- mem_req, mem_we, mem_func3, mem_addr, mem_wdata ; mem_ack, mem_rdata ->
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;
  logic              if_stall;

  logic              d_req;
  logic              d_we;
  logic [2:0]        d_func3;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ready;
  logic              d_stall;

  logic              mem_req;
  logic              mem_we;
  logic [2:0]        mem_func3;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  if_req, if_addr, if_flush,
    output if_rdata, if_ready, if_stall,
    input  d_req, d_we, d_func3, d_addr, d_wdata,
    output d_rdata, d_ready, d_stall,
    output mem_req, mem_we, mem_func3, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    output if_req, if_addr, if_flush,
    input  if_rdata, if_ready, if_stall,
    output d_req, d_we, d_func3, d_addr, d_wdata,
    input  d_rdata, d_ready, d_stall,
    input  mem_req, mem_we, mem_func3, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );

endinterface

// File: rtl/mem_arb_perf_cnt.sv
// mem_arb_perf_cnt: saturating event counter used for arbiter statistics
// (instantiated only when ARB_PERF_CNT_EN is defined).
//   clk : clock
//   rst : asynchronous active-low reset, clears the count
//   inc : count enable for this cycle
//   cnt : current count, sticks at all-ones
module mem_arb_perf_cnt #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one multi-cycle memory port between the IF-stage
// fetch port and the MEM-stage load/store port. Data accesses win conflicts.
// A taken-branch flush cancels an in-flight fetch: the memory transaction
// still completes, but its result is discarded.
//   clk          : clock, rising edge
//   rst          : asynchronous active-low reset
//   bus          : fetch / data / memory signals (mem_port_arbiter_if.master)
//   if_wait_cnt  : cycles with if_stall       (ARB_PERF_CNT_EN, else 0)
//   d_wait_cnt   : cycles with d_stall        (ARB_PERF_CNT_EN, else 0)
//   conflict_cnt : IDLE cycles with both reqs (ARB_PERF_CNT_EN, else 0)
// Optional feature macro: ARB_PERF_CNT_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_port_arbiter_if.master   bus,
  output logic [CNT_W-1:0]     if_wait_cnt,
  output logic [CNT_W-1:0]     d_wait_cnt,
  output logic [CNT_W-1:0]     conflict_cnt
);

  arb_state_t state_q, state_d;

  logic grant_d, grant_i, ack_i, ack_d, deliver_i;
  logic drop_q;

  logic              mem_req_q;
  logic              mem_we_q;
  logic [2:0]        mem_func3_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              if_ready_q;
  logic              d_ready_q;
  logic              if_stall_w;
  logic              d_stall_w;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.d_req) begin
          state_d = DBUSY;
        end else if (bus.if_req && !bus.if_flush) begin
          state_d = IBUSY;
        end
      end
      IBUSY, DBUSY: begin
        if (bus.mem_ack) begin
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control decode
  always_comb begin
    grant_d   = (state_q == IDLE) && bus.d_req;
    grant_i   = (state_q == IDLE) && !bus.d_req && bus.if_req && !bus.if_flush;
    ack_i     = (state_q == IBUSY) && bus.mem_ack;
    ack_d     = (state_q == DBUSY) && bus.mem_ack;
    // A flush landing in the ack cycle itself discards the fetch as well.
    deliver_i = ack_i && !drop_q && !bus.if_flush;
  end

  // Registered memory-side request and requester-side responses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_func3_q <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_ready_q  <= 1'b0;
      d_ready_q   <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      if_ready_q <= 1'b0;
      d_ready_q  <= 1'b0;

      if (grant_d) begin
        mem_req_q   <= 1'b1;
        mem_we_q    <= bus.d_we;
        mem_func3_q <= bus.d_func3;
        mem_addr_q  <= bus.d_addr;
        mem_wdata_q <= bus.d_wdata;
      end else if (grant_i) begin
        // Fetches are always full-word reads, whatever the last data size was.
        mem_req_q   <= 1'b1;
        mem_we_q    <= 1'b0;
        mem_func3_q <= F3_W;
        mem_addr_q  <= bus.if_addr;
      end

      if (ack_i || ack_d) begin
        mem_req_q <= 1'b0;
      end

      if (deliver_i) begin
        if_rdata_q <= bus.mem_rdata;
        if_ready_q <= 1'b1;
      end

      if (ack_d) begin
        d_rdata_q <= bus.mem_rdata;
        d_ready_q <= 1'b1;
      end

      if (ack_i) begin
        drop_q <= 1'b0;
      end else if ((state_q == IBUSY) && bus.if_flush) begin
        drop_q <= 1'b1;
      end
    end
  end

  assign if_stall_w = bus.if_req & ~if_ready_q;
  assign d_stall_w  = bus.d_req & ~d_ready_q;

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_func3 = mem_func3_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_ready  = if_ready_q;
  assign bus.if_stall  = if_stall_w;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.d_ready   = d_ready_q;
  assign bus.d_stall   = d_stall_w;

`ifdef ARB_PERF_CNT_EN
  mem_arb_perf_cnt #(.W(CNT_W)) u_if_wait_cnt (
    .clk (clk),
    .rst (rst),
    .inc (if_stall_w),
    .cnt (if_wait_cnt)
  );

  mem_arb_perf_cnt #(.W(CNT_W)) u_d_wait_cnt (
    .clk (clk),
    .rst (rst),
    .inc (d_stall_w),
    .cnt (d_wait_cnt)
  );

  mem_arb_perf_cnt #(.W(CNT_W)) u_conflict_cnt (
    .clk (clk),
    .rst (rst),
    .inc ((state_q == IDLE) && bus.if_req && bus.d_req),
    .cnt (conflict_cnt)
  );
`else
  assign if_wait_cnt  = '0;
  assign d_wait_cnt   = '0;
  assign conflict_cnt = '0;
`endif

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates the single unified instruction/data memory between the IF-stage fetch port and the MEM-stage load/store port.
- Drives one multi-cycle memory port with a req/ack handshake and returns a per-requester stall to the pipeline.
- On conflict the data access wins, because it belongs to the older instruction.
- Supports cancellation of an in-flight fetch on a taken branch or jump flush.

Parameters:
- ADDR_W, 32, byte-address width on all ports
- DATA_W, 32, data width on all ports
- CNT_W, 32, width of the performance counters (optional feature only)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held until if_ready or flush
- if_addr  in  ADDR_W  fetch address (PC)
- if_flush  in  1  cancel any pending or in-flight fetch
- if_rdata  out  DATA_W  fetched instruction; valid when if_ready=1
- if_ready  out  1  one-cycle pulse: fetch complete
- if_stall  out  1  if_req & ~if_ready
- d_req  in  1  load/store request; held until d_ready
- d_we  in  1  1=store, 0=load
- d_func3  in  3  access size/sign (funct3 encoding: LB/LH/LW/LBU/LHU, SB/SH/SW)
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data; valid when d_ready=1
- d_ready  out  1  one-cycle pulse: data access complete
- d_stall  out  1  d_req & ~d_ready
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  memory write enable
- mem_func3  out  3  forwarded funct3
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_ack  in  1  one-cycle completion pulse from memory
- mem_rdata  in  DATA_W  read data, valid with mem_ack

Behaviour:
- FSM states: IDLE, IBUSY, DBUSY, RESP.
- Reset (rst=0, asynchronous): state=IDLE; mem_req, mem_we, if_ready, d_ready = 0; mem_addr, mem_wdata, mem_func3, if_rdata, d_rdata = 0; drop flag = 0.
- IDLE:
  - d_req=1 → latch d_we/d_func3/d_addr/d_wdata into the mem_* registers; mem_req=1; go to DBUSY.
  - else if_req=1 and if_flush=0 → latch if_addr; mem_we=0; mem_req=1; go to IBUSY.
  - Both requests present in the same cycle → data granted first; fetch keeps stalling.
- mem_* outputs are registered. mem_req rises the cycle after the grant decision and stays high with stable address/data until mem_ack.
- IBUSY / DBUSY, on mem_ack:
  - mem_req=0; capture mem_rdata into if_rdata or d_rdata.
  - Assert the matching ready for exactly one cycle (registered, the cycle after ack).
  - Go to RESP.
- Fetch cancellation:
  - if_flush in IBUSY sets the drop flag. The transaction still completes on the memory side; on its ack, if_ready stays 0 and if_rdata is not updated. The drop flag clears on entering RESP.
  - if_flush in IDLE suppresses a fetch grant that cycle only.
  - if_flush never affects a data transaction.
- RESP: lasts one cycle, then IDLE. Requesters drop or update their req in this cycle, so no grant is issued in RESP. Back-to-back latency is 1 grant cycle + memory latency + 1 response cycle.
- Minimum latency with a 1-cycle memory: request at cycle N, mem_req at N+1, mem_ack at N+1, ready at N+2.
- Protocol rule: requesters must hold req and payload until ready. Dropping d_req before d_ready is illegal. Dropping if_req is legal only together with if_flush.
- if_stall and d_stall are combinational from req and ready, so the pipeline freezes in the same cycle it requests.
- mem_ack outside IBUSY/DBUSY is ignored.
- Asserting rst mid-transaction aborts it. No ready is issued; the memory is expected to be reset by the same rst.

Optional Feature:
- Macro ARB_PERF_CNT_EN.
- Defined: adds outputs if_wait_cnt, d_wait_cnt, conflict_cnt, each CNT_W bits, reset to 0.
  - if_wait_cnt increments on every cycle with if_stall=1.
  - d_wait_cnt increments on every cycle with d_stall=1.
  - conflict_cnt increments on every IDLE cycle with if_req & d_req.
  - All three saturate at all-ones.
- Undefined: the same ports exist but are tied to 0, and no counter flops are built, so the interface stays stable.

Decomposition:
- Shared package/header mem_arb_pkg:
  - FSM state encoding (IDLE=2'd0, IBUSY=2'd1, DBUSY=2'd2, RESP=2'd3)
  - funct3 access-size constants
  - CNT_W default
- One natural sub-module, mem_arb_perf_cnt: a saturating counter instantiated three times under ARB_PERF_CNT_EN.
- Everything else stays in mem_port_arbiter.

Test Plan:
- Fetch only, memory acks 2 cycles after mem_req, if_addr=0x40, mem_rdata=0x00500093 → mem_addr=0x40, mem_we=0; if_ready pulses once; if_rdata=0x00500093; if_stall high until that cycle.
- Simultaneous if_req (0x44) and d_req store (addr 0x80, wdata 0xDEADBEEF, func3=3'b010) → store is issued first (mem_we=1, mem_addr=0x80), then fetch 0x44 after RESP; d_ready precedes if_ready.
- Fetch 0x48 in flight, if_flush pulsed one cycle before mem_ack → no if_ready, if_rdata unchanged; the next fetch 0x100 completes normally.
- Load with func3=3'b100 at 0x83, mem_rdata=0x000000FF, 1-cycle memory → d_ready exactly 2 cycles after d_req; d_rdata=0x000000FF; mem_func3=3'b100.
- rst driven low while in DBUSY → all outputs 0 immediately (asynchronous); state IDLE; after release, a new fetch completes normally.
- With ARB_PERF_CNT_EN: 5 conflict cycles and a 3-cycle fetch wait → conflict_cnt=5; if_wait_cnt counts every if_stall cycle; counters preloaded near all-ones hold at all-ones.
